dmul_bi_param: RTL

Parametrised deterministic unary multiplier: two INWD-bit binary operands are loaded, then a start command launches one full-precision pass of exactly 2^(2·INWD) cycles. During the pass it emits a product bitstream built from clock-division (fast/slow counter) comparator encoding, so the result is exact rather than approximate. It replaces the fixed-width bipolar multiplier in the unary compute path. It adds a width parameter, unipolar/bipolar mode, explicit start/busy/done sequencing and an optional on-chip ones counter.

---
 rtl/dmul_bi_param.sv | 90 +++++++++
 1 files changed

// File: rtl/dmul_bi_param.sv
// dmul_bi_param: exact unary multiplier; product bitstream from fast/slow counter comparator encoding.
// Latency: stream bit k appears k+1 cycles after start; busy for 2^(2*INWD) cycles, then a one-cycle done.
// Backpressure: none; loads and start are ignored while busy. Optional ones counter: `define DMUL_BI_ACC_EN.
module dmul_bi_param #(
  parameter int INWD    = 8,
  parameter bit BIPOLAR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [INWD-1:0] iA,
  input  logic [INWD-1:0] iB,
  input  logic            loadA,
  input  logic            loadB,
  input  logic            start,
  output logic            busy,
  output logic            done,
`ifdef DMUL_BI_ACC_EN
  output logic [2*INWD:0] oCnt,
`endif
  output logic            oC
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [INWD-1:0] reg_a, reg_b;
  logic [INWD-1:0] cnt_a, cnt_b;
  logic            bit_a, bit_b;
  logic            start_ok;

  assign start_ok = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      reg_a <= '0;
      reg_b <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (loadA) reg_a <= iA;
          if (loadB) reg_b <= iB;
          if (start) begin
            state <= RUN;
            cnt_a <= '0;
            cnt_b <= '0;
          end
        end
        RUN: begin
          // cnt_a is the fast digit, cnt_b the slow one: together they sweep every (a,b) pair once.
          cnt_a <= cnt_a + 1'b1;
          if (cnt_a == '1) begin
            cnt_b <= cnt_b + 1'b1;
            if (cnt_b == '1) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == RUN);
  assign bit_a = (cnt_a < reg_a);
  assign bit_b = (cnt_b < reg_b);
  assign oC    = busy & ((BIPOLAR != 1'b0) ? ~(bit_a ^ bit_b) : (bit_a & bit_b));

`ifdef DMUL_BI_ACC_EN
  logic [2*INWD:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (start_ok) begin
      acc <= '0;
    end else if (oC) begin
      acc <= acc + 1'b1;
    end
  end

  assign oCnt = acc;
`endif

endmodule
